// File: rtl/scrambler_seq_ctrl.sv
// -----------------------------------------------------------------------------
// scrambler_seq_ctrl
//
// Frame sequencer wrapped around a WIDTH-stage XOR-feedback shift register
// (LFSR scrambler). On start it latches a seed and a frame length. It then
// scrambles exactly frame_len bits from a bit-serial source and passes them
// to a bit-serial sink. Both sides use a valid/ready handshake. When the
// frame ends it pulses done.
//
// Optional feature (macro SCR_APPEND_STATE_EN):
//   When this macro is defined, the final register contents follow the data
//   bits. They are emitted MSB first as WIDTH extra bits before done. When
//   it is undefined, the frame ends as soon as the last data bit has been
//   consumed.
//
// Parameters:
//   WIDTH  shift-register length (>= 2)
//   TAPS   feedback tap mask; bit i set puts state[i] into the XOR
//   LEN_W  width of frame_len and bit_cnt
//
// Ports:
//   d_clk      in   clock, rising edge
//   d_rst_n    in   asynchronous active-low reset
//   start      in   begin frame (sampled only in IDLE)
//   frame_len  in   number of data bits in the frame (latched with start)
//   seed       in   initial register value (latched with start)
//   abort      in   synchronous abort back to IDLE, no done
//   in_valid   in   source bit valid
//   in_data    in   source bit
//   in_ready   out  controller accepts in_data this cycle
//   out_valid  out  out_data valid
//   out_data   out  scrambled (or appended) bit
//   out_ready  in   sink accepts out_data
//   busy       out  controller not in IDLE
//   done       out  one-cycle pulse at frame end
//   bit_cnt    out  data bits accepted in the current frame
// -----------------------------------------------------------------------------
module scrambler_seq_ctrl #(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = 3'b110,
  parameter int               LEN_W = 8
) (
  input  logic             d_clk,
  input  logic             d_rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [WIDTH-1:0] seed,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_cnt
);

`ifdef SCR_APPEND_STATE_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    APPEND = 3'd4
  } state_t;

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  // Position in lfsr of the appended bit currently on out_data.
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_m1;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3
  } state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] seed_q;
  logic [LEN_W-1:0] len_q;
  logic             fb;
  logic             xfer;
  logic             last_bit;

  // The output register can take a new bit when it is empty or is being
  // drained in this same cycle.
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign busy     = (state != IDLE);
  assign xfer     = in_valid && in_ready;
  assign last_bit = (bit_cnt == (len_q - LEN_W'(1)));

  always_comb begin
    fb = in_data ^ (^(lfsr & TAPS));
  end

`ifdef SCR_APPEND_STATE_EN
  assign idx_m1 = idx - IDX_W'(1);
`endif

  always_ff @(posedge d_clk or negedge d_rst_n) begin
    if (!d_rst_n) begin
      state     <= IDLE;
      lfsr      <= '0;
      seed_q    <= '0;
      len_q     <= '0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      done      <= 1'b0;
`ifdef SCR_APPEND_STATE_EN
      idx       <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        // Abort drops any pending output bit and suppresses done.
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // Abort beats start, even in IDLE.
            if (start && !abort) begin
              seed_q <= seed;
              len_q  <= frame_len;
              if (frame_len != '0) begin
                state <= LOAD;
              end else begin
                // An empty frame completes immediately without leaving IDLE.
                done <= 1'b1;
              end
            end
          end

          // ---- LOAD: seed the register, clear the counter ----
          LOAD: begin
            lfsr    <= seed_q;
            bit_cnt <= '0;
            state   <= RUN;
          end

          // ---- RUN: scramble one bit per accepted transfer ----
          RUN: begin
            if (xfer) begin
              lfsr      <= {lfsr[WIDTH-2:0], fb};
              out_data  <= fb;
              out_valid <= 1'b1;
              bit_cnt   <= bit_cnt + LEN_W'(1);
              if (last_bit) begin
                state <= DRAIN;
              end
            end else if (out_ready) begin
              out_valid <= 1'b0;
            end
          end

          // ---- DRAIN: wait for the last data bit to leave ----
          DRAIN: begin
            if (!out_valid || out_ready) begin
`ifdef SCR_APPEND_STATE_EN
              state     <= APPEND;
              out_valid <= 1'b1;
              out_data  <= lfsr[WIDTH-1];
              idx       <= IDX_W'(WIDTH - 1);
`else
              state     <= IDLE;
              out_valid <= 1'b0;
              done      <= 1'b1;
`endif
            end
          end

`ifdef SCR_APPEND_STATE_EN
          // ---- APPEND: shift out the frozen register, MSB first ----
          APPEND: begin
            if (out_ready) begin
              if (idx == '0) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                done      <= 1'b1;
              end else begin
                idx      <= idx_m1;
                out_data <= lfsr[idx_m1];
              end
            end
          end
`endif

          default: begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scrambler_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_scrambler_seq_ctrl
//
// Directed bench for scrambler_seq_ctrl (WIDTH=3, TAPS=3'b110). It covers
// the following cases:
//   - reset values, including a reset applied in the middle of a frame
//   - normal frames with several seeds and data patterns
//   - sink backpressure
//   - a zero-length frame
//   - abort followed by a new start
// The expected scrambled bits were worked out by hand from
//   fb = in ^ lfsr[2] ^ lfsr[1].
// The appended-state tail is checked only when SCR_APPEND_STATE_EN is defined.
// -----------------------------------------------------------------------------
module tb_scrambler_seq_ctrl;

  localparam int WIDTH = 3;
  localparam int LEN_W = 8;

  logic             d_clk = 1'b0;
  logic             d_rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic [WIDTH-1:0] seed = '0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_data = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic             out_data;
  logic             out_ready = 1'b1;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] bit_cnt;

  int checks = 0;
  int errors = 0;

  scrambler_seq_ctrl #(
    .WIDTH (WIDTH),
    .TAPS  (3'b110),
    .LEN_W (LEN_W)
  ) dut (
    .d_clk     (d_clk),
    .d_rst_n   (d_rst_n),
    .start     (start),
    .frame_len (frame_len),
    .seed      (seed),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .bit_cnt   (bit_cnt)
  );

  always #5 d_clk = ~d_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge d_clk);
    #1;
  endtask

  // Issue start for a 4-bit frame; leaves the DUT in RUN.
  task automatic begin_frame(input logic [WIDTH-1:0] sd, input string tag);
    start     = 1'b1;
    frame_len = 8'd4;
    seed      = sd;
    tick();
    start     = 1'b0;
    frame_len = 8'd77;   // changes after start must be ignored
    seed      = 3'b010;
    chk({tag, "_load_busy"}, busy, 1);
    chk({tag, "_load_in_ready"}, in_ready, 0);
    tick();
    chk({tag, "_run_in_ready"}, in_ready, 1);
  endtask

  // From DRAIN: check the optional tail, the done pulse and the final count.
  task automatic end_frame(input logic [WIDTH-1:0] fin, input int cnt, input string tag);
    chk({tag, "_drain_in_ready"}, in_ready, 0);
    chk({tag, "_drain_no_done"}, done, 0);
`ifdef SCR_APPEND_STATE_EN
    for (int j = 0; j < WIDTH; j++) begin
      tick();
      chk({tag, "_app_valid"}, out_valid, 1);
      chk({tag, "_app_data"}, out_data, fin[WIDTH-1-j]);
      chk({tag, "_app_no_done"}, done, 0);
    end
`else
    if (fin === 'x) chk({tag, "_fin_defined"}, 0, 1);
`endif
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_out_valid"}, out_valid, 0);
    chk({tag, "_bit_cnt"}, bit_cnt, cnt);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_bit_cnt_hold"}, bit_cnt, cnt);
  endtask

  // Full 4-bit frame with out_ready held high. bits[i] and expo[i] are the
  // i-th input bit and the i-th expected output bit.
  task automatic run_frame(input logic [WIDTH-1:0] sd, input logic [3:0] bits,
                           input logic [3:0] expo, input logic [WIDTH-1:0] fin,
                           input string tag);
    begin_frame(sd, tag);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = bits[i];
      tick();
      chk({tag, "_out_valid"}, out_valid, 1);
      chk({tag, "_out_data"}, out_data, expo[i]);
      chk({tag, "_cnt"}, bit_cnt, i + 1);
    end
    in_valid = 1'b0;
    end_frame(fin, 4, tag);
  endtask

  initial begin
    // Reset values
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    d_rst_n = 1'b1;
    tick();

    // Basic frame: seed 0, in 1,0,0,0 -> out 1,0,1,1, final lfsr 011
    run_frame(3'b000, 4'b0001, 4'b1101, 3'b011, "t2");

    // Second pattern: seed 111, in 1,1,0,1 -> out 1,1,0,1, final lfsr 101
    run_frame(3'b111, 4'b1011, 4'b1011, 3'b101, "t2b");

    // Backpressure: sink stalls for 3 cycles after the second bit
    begin_frame(3'b000, "t4");
    in_valid = 1'b1;
    in_data  = 1'b1;
    tick();
    chk("t4_b0", out_data, 1);
    in_data = 1'b0;
    tick();
    chk("t4_b1", out_data, 0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_stall_in_ready", in_ready, 0);
      chk("t4_stall_valid", out_valid, 1);
      chk("t4_stall_data", out_data, 0);
      chk("t4_stall_cnt", bit_cnt, 2);
    end
    out_ready = 1'b1;
    tick();
    chk("t4_b2", out_data, 1);
    chk("t4_b2_cnt", bit_cnt, 3);
    tick();
    chk("t4_b3", out_data, 1);
    chk("t4_b3_cnt", bit_cnt, 4);
    in_valid = 1'b0;
    end_frame(3'b011, 4, "t4");

    // Zero-length frame
    start     = 1'b1;
    frame_len = 8'd0;
    tick();
    start = 1'b0;
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 0);
    chk("t5_out_valid", out_valid, 0);
    tick();
    chk("t5_done_pulse", done, 0);
    chk("t5_busy2", busy, 0);

    // Abort after 2 of 4 bits, then a normal frame
    begin_frame(3'b000, "t6");
    in_valid = 1'b1;
    in_data  = 1'b1;
    tick();
    in_data = 1'b0;
    tick();
    chk("t6_cnt2", bit_cnt, 2);
    in_valid = 1'b0;
    abort    = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_valid", out_valid, 0);
    chk("t6_abort_done", done, 0);
    tick();
    chk("t6_abort_done2", done, 0);
    run_frame(3'b000, 4'b0001, 4'b1101, 3'b011, "t6r");

    // Reset in the middle of RUN
    begin_frame(3'b000, "t1");
    in_valid = 1'b1;
    in_data  = 1'b1;
    tick();
    chk("t1_pre_valid", out_valid, 1);
    in_valid = 1'b0;
    d_rst_n  = 1'b0;
    #1;
    chk("t1_rst_valid", out_valid, 0);
    chk("t1_rst_data", out_data, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_in_ready", in_ready, 0);
    chk("t1_rst_cnt", bit_cnt, 0);
    chk("t1_rst_done", done, 0);
    tick();
    d_rst_n = 1'b1;
    tick();
    chk("t1_post_busy", busy, 0);
    chk("t1_post_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
